// File: rtl/x_and_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : x_and_pipe_pkg
// Purpose  : Shared constants and elaboration-time helpers for the pipelined
//            AND-reduction tree (stage count, index width, lanes per level,
//            legal parameter ranges).
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package x_and_pipe_pkg;

  localparam int WIDTH_MIN = 2;
  localparam int WIDTH_MAX = 256;
  localparam int GROUP_MIN = 2;
  localparam int GROUP_MAX = 8;

  // Ceiling log2; clog2(1) = 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  // Number of lanes left after 'level' reduction levels.
  function automatic int lanes_after(input int width, input int group, input int level);
    int n;
    n = width;
    for (int s = 0; s < level; s++) n = (n + group - 1) / group;
    return n;
  endfunction

  // Number of registered levels needed to reduce 'width' lanes to one.
  function automatic int num_stages(input int width, input int group);
    int n;
    int s;
    n = width;
    s = 0;
    while (n > 1) begin
      n = (n + group - 1) / group;
      s++;
    end
    return s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/x_and_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : x_and_pipe_stage
// Purpose  : One registered level of the AND-reduction tree. Each output lane
//            merges GROUP input lanes: all-ones flag is the AND of the group,
//            index is taken from the lowest-numbered lane holding a zero.
// Ports    : clk, rst_n (async, active low), ce (hold when low)
//            valid_in/valid_out - valid bit travelling beside the data
//            ones_in  [N_IN]    / ones_out [N_OUT]     - per-lane all-ones flag
//            idx_in   [N_IN*IDXW]/ idx_out [N_OUT*IDXW] - per-lane lowest-zero index
// Revision : 1.0 - initial release
// ============================================================================
module x_and_pipe_stage
  import x_and_pipe_pkg::*;
#(
  parameter int N_IN  = 32,
  parameter int GROUP = 4,
  parameter int IDXW  = 5
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         ce,
  input  logic                                         valid_in,
  input  logic [N_IN-1:0]                              ones_in,
  input  logic [N_IN*IDXW-1:0]                         idx_in,
  output logic                                         valid_out,
  output logic [lanes_after(N_IN, GROUP, 1)-1:0]       ones_out,
  output logic [lanes_after(N_IN, GROUP, 1)*IDXW-1:0]  idx_out
);

  localparam int N_OUT = lanes_after(N_IN, GROUP, 1);
  localparam int N_PAD = N_OUT * GROUP;

  // Missing lanes of the last group are padded with "all ones" so they can
  // never win the lowest-zero selection.
  logic [N_PAD-1:0]      ones_pad;
  logic [N_PAD*IDXW-1:0] idx_pad;

  if (N_PAD > N_IN) begin : g_pad
    assign ones_pad = {{(N_PAD - N_IN){1'b1}}, ones_in};
    assign idx_pad  = {{((N_PAD - N_IN) * IDXW){1'b0}}, idx_in};
  end else begin : g_nopad
    assign ones_pad = ones_in;
    assign idx_pad  = idx_in;
  end

  logic [N_OUT-1:0]      ones_d;
  logic [N_OUT*IDXW-1:0] idx_d;

  // Scan each group from its highest lane down so the lowest zero lane is the
  // last one written and therefore wins.
  always_comb begin
    ones_d = '1;
    idx_d  = '0;
    for (int o = 0; o < N_OUT; o++) begin
      for (int g = GROUP - 1; g >= 0; g--) begin
        if (!ones_pad[o*GROUP + g]) begin
          ones_d[o]                = 1'b0;
          idx_d[o*IDXW +: IDXW]    = idx_pad[(o*GROUP + g)*IDXW +: IDXW];
        end
      end
    end
  end

  // Data loads on every enabled cycle regardless of valid; valid alone
  // qualifies the meaning of the word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      ones_out  <= '0;
      idx_out   <= '0;
    end else if (ce) begin
      valid_out <= valid_in;
      ones_out  <= ones_d;
      idx_out   <= idx_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/x_and_pipe.sv
`default_nettype none
// ============================================================================
// Module   : x_and_pipe
// Purpose  : Pipelined AND/NAND reduction of a WIDTH-bit word through a tree
//            of registered GROUP-input stages, also reporting the index of the
//            lowest zero bit and a pre-inversion all-ones flag.
// Ports    : CLK      - clock, rising edge
//            RST_N    - asynchronous active-low reset
//            CE       - clock enable, low freezes the whole pipeline
//            I        - input word, I_VALID qualifies it
//            O        - O_ALLONE xor INVERT
//            O_VALID  - outputs belong to a valid input word
//            O_IDX    - lowest zero bit index (0 when no zero bit)
//            O_ALLONE - every bit of the word was 1
// Revision : 1.0 - initial release
// ============================================================================
module x_and_pipe
  import x_and_pipe_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int GROUP  = 4,
  parameter int INVERT = 0
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       CE,
  input  logic [WIDTH-1:0]           I,
  input  logic                       I_VALID,
  output logic                       O,
  output logic                       O_VALID,
  output logic [clog2(WIDTH)-1:0]    O_IDX,
  output logic                       O_ALLONE
);

  localparam int STAGES = num_stages(WIDTH, GROUP);
  localparam int IDXW   = clog2(WIDTH);

  if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_bad_width
    $error("x_and_pipe: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
  end
  if (GROUP < GROUP_MIN || GROUP > GROUP_MAX) begin : g_bad_group
    $error("x_and_pipe: GROUP %0d outside %0d..%0d", GROUP, GROUP_MIN, GROUP_MAX);
  end
  if (INVERT != 0 && INVERT != 1) begin : g_bad_invert
    $error("x_and_pipe: INVERT %0d must be 0 or 1", INVERT);
  end

  // Each level owns a WIDTH-lane slot in these flat chains; only the low
  // lanes_after(level) lanes are live, the rest are tied off.
  wire [(STAGES+1)*WIDTH-1:0]      ones_chain;
  wire [(STAGES+1)*WIDTH*IDXW-1:0] idx_chain;
  wire [STAGES:0]                  valid_chain;

  assign ones_chain[WIDTH-1:0] = I;
  assign valid_chain[0]        = I_VALID;

  // Level 0 lanes are single bits; their index is simply their bit position.
  for (genvar i = 0; i < WIDTH; i++) begin : g_lane0
    assign idx_chain[i*IDXW +: IDXW] = IDXW'(i);
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int N_IN  = lanes_after(WIDTH, GROUP, k);
    localparam int N_OUT = lanes_after(WIDTH, GROUP, k + 1);

    x_and_pipe_stage #(
      .N_IN  (N_IN),
      .GROUP (GROUP),
      .IDXW  (IDXW)
    ) u_stage (
      .clk       (CLK),
      .rst_n     (RST_N),
      .ce        (CE),
      .valid_in  (valid_chain[k]),
      .ones_in   (ones_chain[k*WIDTH +: N_IN]),
      .idx_in    (idx_chain[k*WIDTH*IDXW +: N_IN*IDXW]),
      .valid_out (valid_chain[k+1]),
      .ones_out  (ones_chain[(k+1)*WIDTH +: N_OUT]),
      .idx_out   (idx_chain[(k+1)*WIDTH*IDXW +: N_OUT*IDXW])
    );

    if (N_OUT < WIDTH) begin : g_fill
      assign ones_chain[(k+1)*WIDTH + N_OUT +: WIDTH - N_OUT]               = '1;
      assign idx_chain[((k+1)*WIDTH + N_OUT)*IDXW +: (WIDTH - N_OUT)*IDXW]  = '0;
    end
  end

  // Tied-off lanes are never read by the tree; fold them here so they are
  // accounted for.
  wire unused_chain = ^{ones_chain, idx_chain};

  // Reset clears the final all-ones register, so O settles at INVERT.
  assign O_ALLONE = ones_chain[STAGES*WIDTH];
  assign O        = ones_chain[STAGES*WIDTH] ^ (INVERT != 0);
  assign O_IDX    = idx_chain[STAGES*WIDTH*IDXW +: IDXW];
  assign O_VALID  = valid_chain[STAGES];

endmodule
`default_nettype wire

// File: tb/tb_x_and_pipe.sv
`default_nettype none
// ============================================================================
// Module   : tb_x_and_pipe
// Purpose  : Self-checking bench for x_and_pipe. Two instances share stimulus:
//            WIDTH=32/GROUP=4/INVERT=0 (latency 3) and WIDTH=10/GROUP=4/
//            INVERT=1 (latency 2). A queue model delays each enabled sample by
//            the latency and computes the reduction directly from the word.
// Revision : 1.0 - initial release
// ============================================================================
module tb_x_and_pipe;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CE;
  logic        I_VALID;
  logic [31:0] I;

  logic       o_a, v_a, all_a;
  logic [4:0] idx_a;
  logic       o_b, v_b, all_b;
  logic [3:0] idx_b;

  always #5 CLK = ~CLK;

  x_and_pipe #(.WIDTH(32), .GROUP(4), .INVERT(0)) dut_a (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .I(I), .I_VALID(I_VALID),
    .O(o_a), .O_VALID(v_a), .O_IDX(idx_a), .O_ALLONE(all_a)
  );

  x_and_pipe #(.WIDTH(10), .GROUP(4), .INVERT(1)) dut_b (
    .CLK(CLK), .RST_N(RST_N), .CE(CE), .I(I[9:0]), .I_VALID(I_VALID),
    .O(o_b), .O_VALID(v_b), .O_IDX(idx_b), .O_ALLONE(all_b)
  );

  typedef struct {
    bit          v;
    logic [31:0] w;
  } ent_t;

  ent_t q_a[$];
  ent_t q_b[$];
  ent_t cur_a;
  ent_t cur_b;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Lowest zero bit among the low n bits, -1 if all ones.
  function automatic int lowest_zero(input logic [31:0] w, input int n);
    for (int i = 0; i < n; i++)
      if (w[i] == 1'b0) return i;
    return -1;
  endfunction

  task automatic model_reset();
    ent_t b;
    b.v = 1'b0;
    b.w = '0;
    q_a.delete();
    q_b.delete();
    repeat (2) q_a.push_back(b);   // latency 3 -> 2 entries ahead of the output
    q_b.push_back(b);              // latency 2 -> 1 entry ahead
    cur_a = b;
    cur_b = b;
  endtask

  task automatic compare_outputs();
    int lz;
    check("valid_a", 32'(v_a), 32'(cur_a.v));
    if (cur_a.v) begin
      lz = lowest_zero(cur_a.w, 32);
      check("allone_a", 32'(all_a), (lz < 0) ? 32'd1 : 32'd0);
      check("o_a",      32'(o_a),   (lz < 0) ? 32'd1 : 32'd0);
      check("idx_a",    32'(idx_a), (lz < 0) ? 32'd0 : 32'(lz));
    end
    check("valid_b", 32'(v_b), 32'(cur_b.v));
    if (cur_b.v) begin
      lz = lowest_zero(cur_b.w, 10);
      check("allone_b", 32'(all_b), (lz < 0) ? 32'd1 : 32'd0);
      check("o_b",      32'(o_b),   (lz < 0) ? 32'd0 : 32'd1);
      check("idx_b",    32'(idx_b), (lz < 0) ? 32'd0 : 32'(lz));
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic tick(input bit ce_i, input bit v_i, input logic [31:0] w_i);
    ent_t e;
    CE      = ce_i;
    I_VALID = v_i;
    I       = w_i;
    @(posedge CLK);
    #1;
    if (ce_i) begin
      e.v = v_i;
      e.w = w_i;
      q_a.push_back(e);
      cur_a = q_a.pop_front();
      q_b.push_back(e);
      cur_b = q_b.pop_front();
    end
    compare_outputs();
    @(negedge CLK);
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    case ($urandom % 5)
      0: w = 32'hFFFF_FFFF;
      1: begin w = 32'hFFFF_FFFF; w[$urandom % 32] = 1'b0; end
      2: begin w = 32'hFFFF_FFFF; w[$urandom % 10] = 1'b0; end
      3: begin w = 32'hFFFF_FFFF; w[$urandom % 32] = 1'b0; w[$urandom % 32] = 1'b0; end
      default: w = $urandom;
    endcase
    return w;
  endfunction

  initial begin
    RST_N = 1'b0;
    CE = 1'b0;
    I_VALID = 1'b0;
    I = '0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check("rst_valid_a",  32'(v_a),   32'd0);
    check("rst_o_a",      32'(o_a),   32'd0);
    check("rst_allone_a", 32'(all_a), 32'd0);
    check("rst_idx_a",    32'(idx_a), 32'd0);
    check("rst_valid_b",  32'(v_b),   32'd0);
    check("rst_o_b",      32'(o_b),   32'd1);
    @(negedge CLK);
    RST_N = 1'b1;

    // Single all-ones word: one valid output cycle, three cycles later.
    tick(1, 1, 32'hFFFF_FFFF);
    tick(1, 0, 32'h0);
    tick(1, 0, 32'h0);
    check("one_o",      32'(o_a),   32'd1);
    check("one_allone", 32'(all_a), 32'd1);
    check("one_idx",    32'(idx_a), 32'd0);
    check("one_valid",  32'(v_a),   32'd1);
    tick(1, 0, 32'h0);
    check("one_valid_drop", 32'(v_a), 32'd0);

    // Back-to-back words with differing lowest-zero positions.
    tick(1, 1, 32'hFFFF_7FFF);
    tick(1, 1, 32'h8000_0000);
    tick(1, 1, 32'hFFFF_FFFE);
    check("b2b_idx0", 32'(idx_a), 32'd15);
    check("b2b_o0",   32'(o_a),   32'd0);
    check("b2b_v0",   32'(v_a),   32'd1);
    tick(1, 0, 32'h0);
    check("b2b_idx1", 32'(idx_a), 32'd0);
    check("b2b_v1",   32'(v_a),   32'd1);
    tick(1, 0, 32'h0);
    check("b2b_idx2", 32'(idx_a), 32'd0);
    check("b2b_v2",   32'(v_a),   32'd1);
    tick(1, 0, 32'h0);
    check("b2b_end",  32'(v_a),   32'd0);

    // Narrow NAND instance: padded lanes must not affect the result.
    tick(1, 1, 32'h0000_03FF);
    tick(1, 1, 32'h0000_01FF);
    check("w10_o0",      32'(o_b),   32'd0);
    check("w10_allone0", 32'(all_b), 32'd1);
    tick(1, 0, 32'h0);
    check("w10_o1",   32'(o_b),   32'd1);
    check("w10_idx1", 32'(idx_b), 32'd9);
    tick(1, 0, 32'h0);
    tick(1, 0, 32'h0);

    // Clock-enable stall in the middle of a stream.
    tick(1, 1, 32'hFFFF_FFEF);
    tick(1, 1, 32'hFFFF_FFFF);
    tick(0, 1, 32'h1234_5678);
    tick(0, 0, 32'h0);
    tick(1, 1, 32'hFBFF_FFFF);
    tick(1, 1, 32'hFFFF_FDFF);
    repeat (4) tick(1, 0, 32'h0);

    // Asynchronous reset with three words in flight.
    tick(1, 1, 32'hFFFF_FFFF);
    tick(1, 1, 32'h0000_0000);
    tick(1, 1, 32'hFFFF_FFFF);
    RST_N = 1'b0;
    #1;
    check("arst_valid_a", 32'(v_a), 32'd0);
    check("arst_o_a",     32'(o_a), 32'd0);
    check("arst_valid_b", 32'(v_b), 32'd0);
    check("arst_o_b",     32'(o_b), 32'd1);
    model_reset();
    @(negedge CLK);
    RST_N = 1'b1;
    tick(1, 0, 32'h0);
    tick(1, 1, 32'hFFEF_FFFF);
    tick(1, 0, 32'h0);
    tick(1, 0, 32'h0);
    check("arst_next_v",   32'(v_a),   32'd1);
    check("arst_next_idx", 32'(idx_a), 32'd20);
    tick(1, 0, 32'h0);

    // Randomized stream with random enable and valid.
    for (int n = 0; n < 10000; n++) begin
      tick(($urandom % 4) != 0, ($urandom % 4) != 0, rand_word());
    end
    repeat (4) tick(1, 0, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
